// File: rtl/diff_eq_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : diff_eq_multichannel
// Description : Time-interleaved, multichannel second-order difference
//               equation y = B0*x + B1*x1 + B2*x2 + A1*y1 + A2*y2 computed per
//               channel. Optional macro DIFF_EQ_SATURATION_EN clamps results
//               to the output range (otherwise they wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module diff_eq_multichannel #(
    parameter int N_BITS    = 8,
    parameter int N_CH      = 4,
    parameter int CH_BITS   = 2,
    parameter int COEF_BITS = 4,
    parameter int B0        = 1,
    parameter int B1        = 1,
    parameter int B2        = 1,
    parameter int A1        = 0,
    parameter int A2        = 0
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [N_BITS-1:0]     i_x,
    input  logic [CH_BITS-1:0]    i_ch,
    input  logic                  i_valid,
    input  logic                  i_clear,
    output logic [N_BITS+2:0]     o_y,
    output logic [CH_BITS-1:0]    o_ch,
    output logic                  o_valid,
    output logic                  o_sat,
    output logic                  o_err
);

    localparam int c_out_w = N_BITS + 3;
    localparam int c_acc_w = N_BITS + COEF_BITS + 6;

    localparam logic signed [c_acc_w-1:0] c_b0 = c_acc_w'(B0);
    localparam logic signed [c_acc_w-1:0] c_b1 = c_acc_w'(B1);
    localparam logic signed [c_acc_w-1:0] c_b2 = c_acc_w'(B2);
    localparam logic signed [c_acc_w-1:0] c_a1 = c_acc_w'(A1);
    localparam logic signed [c_acc_w-1:0] c_a2 = c_acc_w'(A2);

    // Per-channel histories
    logic [N_BITS-1:0]  r_x1 [N_CH];
    logic [N_BITS-1:0]  r_x2 [N_CH];
    logic [c_out_w-1:0] r_y1 [N_CH];
    logic [c_out_w-1:0] r_y2 [N_CH];

    logic [c_out_w-1:0] r_y;
    logic [CH_BITS-1:0] r_ch;
    logic               r_valid;
    logic               r_err;

    logic [N_BITS-1:0]  w_x1;
    logic [N_BITS-1:0]  w_x2;
    logic [c_out_w-1:0] w_y1;
    logic [c_out_w-1:0] w_y2;
    logic               w_hit;
    logic signed [c_acc_w-1:0] w_acc;
    logic [c_out_w-1:0] w_y;

    // Select the addressed channel's history; w_hit is low for tags >= N_CH
    always_comb begin
        w_x1  = '0;
        w_x2  = '0;
        w_y1  = '0;
        w_y2  = '0;
        w_hit = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_ch == CH_BITS'(c)) begin
                w_x1  = r_x1[c];
                w_x2  = r_x2[c];
                w_y1  = r_y1[c];
                w_y2  = r_y2[c];
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_acc = c_b0 * c_acc_w'(signed'(i_x))
              + c_b1 * c_acc_w'(signed'(w_x1))
              + c_b2 * c_acc_w'(signed'(w_x2))
              + c_a1 * c_acc_w'(signed'(w_y1))
              + c_a2 * c_acc_w'(signed'(w_y2));
    end

`ifdef DIFF_EQ_SATURATION_EN
    localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'((2 ** (N_BITS + 2)) - 1);
    localparam logic signed [c_acc_w-1:0] c_sat_min = c_acc_w'(-(2 ** (N_BITS + 2)));

    logic w_sat;
    logic r_sat;

    always_comb begin
        w_sat = 1'b0;
        w_y   = w_acc[c_out_w-1:0];
        if (w_acc > c_sat_max) begin
            w_y   = c_sat_max[c_out_w-1:0];
            w_sat = 1'b1;
        end else if (w_acc < c_sat_min) begin
            w_y   = c_sat_min[c_out_w-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= i_valid & ~i_clear & w_hit & w_sat;
        end
    end

    assign o_sat = r_sat;
`else
    // Upper accumulator bits are discarded by two's-complement wrap
    logic w_unused;
    assign w_unused = ^w_acc[c_acc_w-1:c_out_w];
    assign w_y      = w_acc[c_out_w-1:0];
    assign o_sat    = 1'b0;
`endif

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_x1[c] <= '0;
                r_x2[c] <= '0;
                r_y1[c] <= '0;
                r_y2[c] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (i_clear) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_x1[c] <= '0;
                    r_x2[c] <= '0;
                    r_y1[c] <= '0;
                    r_y2[c] <= '0;
                end
            end else if (i_valid) begin
                if (w_hit) begin
                    r_y     <= w_y;
                    r_ch    <= i_ch;
                    r_valid <= 1'b1;
                    // History stores the delivered (clamped/wrapped) result
                    for (int c = 0; c < N_CH; c++) begin
                        if (i_ch == CH_BITS'(c)) begin
                            r_x1[c] <= i_x;
                            r_x2[c] <= r_x1[c];
                            r_y1[c] <= w_y;
                            r_y2[c] <= r_y1[c];
                        end
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_y     = r_y;
    assign o_ch    = r_ch;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_diff_eq_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : tb_diff_eq_multichannel
// Description : Self-checking bench for diff_eq_multichannel with three
//               differently configured instances and a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diff_eq_multichannel;

    localparam int c_ymax = (1 << 10) - 1;
    localparam int c_ymin = -(1 << 10);
    localparam int c_span = 2048;

    localparam int c_b0 [3] = '{1, 1, 2};
    localparam int c_b1 [3] = '{1, 0, -3};
    localparam int c_b2 [3] = '{1, 0, 1};
    localparam int c_a1 [3] = '{0, 1, 1};
    localparam int c_a2 [3] = '{0, 0, -1};
    localparam int c_nch[3] = '{4, 3, 4};

    logic              clock = 1'b0;
    logic              i_reset;
    logic [7:0]        i_x;
    logic [1:0]        i_ch;
    logic              i_valid;
    logic              i_clear;
    logic signed [10:0] o_y    [3];
    logic [1:0]        o_ch   [3];
    logic              o_valid[3];
    logic              o_sat  [3];
    logic              o_err  [3];

    always #5 clock = ~clock;

    diff_eq_multichannel u_dut_a (
        .clock(clock), .i_reset(i_reset), .i_x(i_x), .i_ch(i_ch),
        .i_valid(i_valid), .i_clear(i_clear), .o_y(o_y[0]), .o_ch(o_ch[0]),
        .o_valid(o_valid[0]), .o_sat(o_sat[0]), .o_err(o_err[0])
    );

    diff_eq_multichannel #(
        .N_CH(3), .B0(1), .B1(0), .B2(0), .A1(1), .A2(0)
    ) u_dut_b (
        .clock(clock), .i_reset(i_reset), .i_x(i_x), .i_ch(i_ch),
        .i_valid(i_valid), .i_clear(i_clear), .o_y(o_y[1]), .o_ch(o_ch[1]),
        .o_valid(o_valid[1]), .o_sat(o_sat[1]), .o_err(o_err[1])
    );

    diff_eq_multichannel #(
        .B0(2), .B1(-3), .B2(1), .A1(1), .A2(-1)
    ) u_dut_c (
        .clock(clock), .i_reset(i_reset), .i_x(i_x), .i_ch(i_ch),
        .i_valid(i_valid), .i_clear(i_clear), .o_y(o_y[2]), .o_ch(o_ch[2]),
        .o_valid(o_valid[2]), .o_sat(o_sat[2]), .o_err(o_err[2])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: x[n-1], x[n-2], y[n-1], y[n-2] per instance and channel
    int mx1 [3][4];
    int mx2 [3][4];
    int my1 [3][4];
    int my2 [3][4];
    int ey  [3];
    int ech [3];
    int ev  [3];
    int es  [3];
    int ee  [3];

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    function automatic int fit(input int acc, output int sat);
        int m;
        sat = 0;
`ifdef DIFF_EQ_SATURATION_EN
        if (acc > c_ymax) begin
            sat = 1;
            return c_ymax;
        end
        if (acc < c_ymin) begin
            sat = 1;
            return c_ymin;
        end
`endif
        m = ((acc % c_span) + c_span) % c_span;
        if (m > c_ymax) m -= c_span;
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ey[k] = 0; ech[k] = 0; ev[k] = 0; es[k] = 0; ee[k] = 0;
            for (int c = 0; c < 4; c++) begin
                mx1[k][c] = 0; mx2[k][c] = 0; my1[k][c] = 0; my2[k][c] = 0;
            end
        end
    endtask

    task automatic model_step(input int x, input int ch, input bit v, input bit clr);
        int acc;
        int y;
        int s;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 0; es[k] = 0; ee[k] = 0;
            if (clr) begin
                for (int c = 0; c < 4; c++) begin
                    mx1[k][c] = 0; mx2[k][c] = 0; my1[k][c] = 0; my2[k][c] = 0;
                end
            end else if (v) begin
                if (ch >= c_nch[k]) begin
                    ee[k] = 1;
                end else begin
                    acc = c_b0[k] * x + c_b1[k] * mx1[k][ch] + c_b2[k] * mx2[k][ch]
                        + c_a1[k] * my1[k][ch] + c_a2[k] * my2[k][ch];
                    y = fit(acc, s);
                    mx2[k][ch] = mx1[k][ch]; mx1[k][ch] = x;
                    my2[k][ch] = my1[k][ch]; my1[k][ch] = y;
                    ey[k] = y; ech[k] = ch; ev[k] = 1; es[k] = s;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s/u%0d.y", tag, k), o_y[k], ey[k]);
            check($sformatf("%s/u%0d.ch", tag, k), int'(o_ch[k]), ech[k]);
            check($sformatf("%s/u%0d.valid", tag, k), int'(o_valid[k]), ev[k]);
            check($sformatf("%s/u%0d.sat", tag, k), int'(o_sat[k]), es[k]);
            check($sformatf("%s/u%0d.err", tag, k), int'(o_err[k]), ee[k]);
        end
    endtask

    task automatic step(input string tag, input int x, input int ch, input bit v, input bit clr);
        logic [7:0] xb;
        logic [1:0] cb;
        xb = 8'(x);
        cb = 2'(ch);
        i_x = xb; i_ch = cb; i_valid = v; i_clear = clr;
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        model_step(x, ch, v, clr);
        check_all(tag);
    endtask

    initial begin
        i_reset = 1'b0; i_x = '0; i_ch = '0; i_valid = 1'b0; i_clear = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (3) @(posedge clock);
        #1 i_reset = 1'b1;

        // Steady input on ch0 with default coefficients
        for (int i = 0; i < 4; i++) begin
            step("seq4", 4, 0, 1'b1, 1'b0);
            check("seq4_lit", o_y[0], (i < 3) ? 4 * (i + 1) : 12);
        end

        // Interleaved channels keep separate histories
        step("clr", 0, 0, 1'b0, 1'b1);
        step("il0", 10, 0, 1'b1, 1'b0);
        check("il0_lit", o_y[0], 10);
        step("il1", -3, 1, 1'b1, 1'b0);
        check("il1_lit", o_y[0], -3);
        check("il1_ch", int'(o_ch[0]), 1);
        step("il2", 10, 0, 1'b1, 1'b0);
        check("il2_lit", o_y[0], 20);

        // Integrator on instance b overflows at the ninth sample
        step("clr", 0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step("integ", 127, 0, 1'b1, 1'b0);
            if (i == 8) check("integ8_lit", o_y[1], 1016);
        end
`ifdef DIFF_EQ_SATURATION_EN
        check("integ9_lit", o_y[1], 1023);
        check("integ9_sat", int'(o_sat[1]), 1);
`else
        check("integ9_lit", o_y[1], -905);
        check("integ9_sat", int'(o_sat[1]), 0);
`endif
        step("idle", 0, 0, 1'b0, 1'b0);

        // Clear wins over a simultaneous sample
        step("clr", 0, 0, 1'b0, 1'b1);
        step("cl_a", 4, 0, 1'b1, 1'b0);
        step("cl_b", 4, 0, 1'b1, 1'b0);
        step("cl_c", 4, 0, 1'b1, 1'b1);
        check("cl_drop", int'(o_valid[0]), 0);
        step("cl_d", 4, 0, 1'b1, 1'b0);
        check("cl_lit", o_y[0], 4);

        // Illegal channel tag on the 3-channel instance
        step("clr", 0, 0, 1'b0, 1'b1);
        step("bad", 7, 3, 1'b1, 1'b0);
        check("bad_err", int'(o_err[1]), 1);
        check("bad_valid", int'(o_valid[1]), 0);
        step("bad_next", 5, 0, 1'b1, 1'b0);
        check("bad_next_lit", o_y[1], 5);
        check("bad_next_err", int'(o_err[1]), 0);

        // Asynchronous reset mid-stream
        step("clr", 0, 0, 1'b0, 1'b1);
        step("mr_a", 4, 0, 1'b1, 1'b0);
        step("mr_b", 4, 0, 1'b1, 1'b0);
        i_x = 8'd4; i_valid = 1'b1;
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        check("rst_async_lit", o_y[0], 0);
        i_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 i_reset = 1'b1;
        step("mr_c", 4, 0, 1'b1, 1'b0);
        check("mr_lit", o_y[0], 4);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd", int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
